alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal: 8, 16, 32, 64).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk  input  1  as the single clock; all flops SHALL be rising-edge.
REQ-004 The block SHALL have port clr  input  1  as the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port en  input  1  as the global pipeline enable; when low, all state SHALL hold.
REQ-006 The block SHALL have port in_valid  input  1  to indicate that the operands and opcode are valid.
REQ-007 The block SHALL have port in_ready  output  1  to indicate that stage 1 can accept data.
REQ-008 The block SHALL have ports a and b, each  input  WIDTH  as the operands.
REQ-009 The block SHALL have port op  input  3  as the opcode (alu_pkg::op_t).
REQ-010 The block SHALL have port out_valid  output  1  to indicate that the result is valid.
REQ-011 The block SHALL have port out_ready  input  1  to indicate that the consumer accepts the result.
REQ-012 The block SHALL have port alu_result  output  WIDTH  as the result.
REQ-013 The block SHALL have port flags  output  4  as {N,V,C,Z} for the result.

Function
REQ-014 Opcodes SHALL be: 0 ADD a+b; 1 SUB a-b; 2 SHL a<<b[SHW-1:0]; 3 SHR logical a>>b[SHW-1:0]; 4 AND; 5 OR; 6 XOR; 7 SLT (signed a<b gives 1, else 0).
REQ-015 The pipeline SHALL have two stages: stage 1 registers the operands and opcode, and stage 2 registers the result and flags; latency from an input handshake to out_valid SHALL be 2 clk with no stall.
REQ-016 An input transfer SHALL occur when in_valid, in_ready and en are all high; an output transfer SHALL occur when out_valid, out_ready and en are all high.
REQ-017 in_ready SHALL be high when stage 1 is empty, or when stage 1 will advance in the same cycle (stage 2 is empty or is being drained).
REQ-018 With out_ready held low, the block SHALL hold exactly 2 entries and then deassert in_ready; no data SHALL be lost or duplicated.
REQ-019 Simultaneous input and output transfers SHALL sustain 1 result per clk.
REQ-020 alu_result and flags SHALL remain stable while out_valid is high and out_ready is low.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-022 C SHALL be the carry-out for ADD and NOT borrow for SUB, and 0 for all other ops.
REQ-023 V SHALL be two's-complement overflow for ADD/SUB, and 0 for all other ops.
REQ-024 N SHALL be result[WIDTH-1], and Z SHALL be (result==0).
REQ-025 A shift amount of 0 SHALL return a; shift bits of b above SHW-1 SHALL be ignored.
REQ-026 When en is low, handshakes SHALL be suppressed, and in_ready and out_valid SHALL still reflect the held state.

Reset
REQ-027 While clr is high, both stage valid bits, out_valid, alu_result and flags SHALL be 0, and in_ready SHALL be 0.
REQ-028 When clr asserts mid-operation, in-flight data SHALL be discarded immediately without waiting for clk.
REQ-029 The first input transfer after reset SHALL be possible on the first clk edge after clr deasserts.

Configuration
REQ-030 With macro ALU_PIPE_FLAGS_EN defined, flags SHALL be computed and registered as in REQ-022 to REQ-024.
REQ-031 Without ALU_PIPE_FLAGS_EN, flags SHALL be tied to 4'b0000 and no flag logic or flag registers SHALL be synthesised; all other behaviour SHALL be unchanged.

Structure
REQ-032 Package alu_pkg SHALL hold op_t (3-bit enum OP_ADD..OP_SLT) and the flag bit-index constants FLG_Z, FLG_C, FLG_V and FLG_N.
REQ-033 The combinational datapath SHALL be the sub-module alu_pipe_core (a, b, op produce result and flags), parameterised by WIDTH.
REQ-034 Pipeline control and valid/ready logic SHALL reside in alu_pipe.

Verification
REQ-035 Reset: assert clr mid-stream with 2 entries in flight -> out_valid=0 and alu_result=0 immediately; no stale output after release.
REQ-036 Arithmetic, WIDTH=32: ADD 0x57+0x0E -> 0x65 with C=0. ADD 0xFFFFFFFF+1 -> 0 with Z=1, C=1. SUB 1-2 -> 0xFFFFFFFF with N=1, C=0. ADD 0x7FFFFFFF+1 -> V=1.
REQ-037 Shift/logic: SHL 0x3 by b=0x0F000002 -> 0xC. SHR 0x80000000 by 31 -> 1. AND 0x55555555&0xAAAAAAAA -> 0 with Z=1. XOR of equal operands -> 0. SLT 0xFFFFFFFF vs 1 -> 1.
REQ-038 Backpressure: stream 4 ops with out_ready low -> in_ready drops after 2 accepts. Raise out_ready -> all 4 results arrive in order, one per clk.
REQ-039 en gating: drop en for 3 clk mid-stream -> no transfers occur and outputs hold; the stream resumes in order.
REQ-040 Build the bench with WIDTH=8 with and without ALU_PIPE_FLAGS_EN -> ADD 0xFF+1 gives 0x00; flags are 4'b0000 without the macro, and C=1, Z=1 with it.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
/*******************************************************************************
 * Module   : alu_pkg
 * Purpose  : Opcode enumeration and flag bit positions shared by the ALU pipe.
 * Revision : 1.0 - initial release
 ******************************************************************************/
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SLT = 3'd7
  } op_t;

  // Flags are packed as {N,V,C,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
/*******************************************************************************
 * Module   : alu_pipe_core
 * Purpose  : Combinational ALU datapath; flag outputs exist only when
 *            ALU_PIPE_FLAGS_EN is defined.
 * Revision : 1.0 - initial release
 ******************************************************************************/
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_slt;

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_shamt = b[SHW-1:0];
  assign w_slt   = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = w_sum;
      OP_SUB:  result = w_diff;
      OP_SHL:  result = a << w_shamt;
      OP_SHR:  result = a >> w_shamt;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, w_slt};
      default: result = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  localparam int c_msb = WIDTH - 1;

  logic w_nb_msb;
  logic w_cin_add, w_cout_add;
  logic w_cin_sub, w_cout_sub;

  // Carry into the MSB is recovered from the sum bit, avoiding a WIDTH+1 adder.
  assign w_cin_add  = w_sum[c_msb] ^ a[c_msb] ^ b[c_msb];
  assign w_cout_add = (a[c_msb] & b[c_msb]) | ((a[c_msb] ^ b[c_msb]) & w_cin_add);

  // Subtraction is a + ~b + 1, so its carry-out is already "not borrow".
  assign w_nb_msb   = ~b[c_msb];
  assign w_cin_sub  = w_diff[c_msb] ^ a[c_msb] ^ w_nb_msb;
  assign w_cout_sub = (a[c_msb] & w_nb_msb) | ((a[c_msb] ^ w_nb_msb) & w_cin_sub);

  always_comb begin
    flags        = 4'b0000;
    flags[FLG_N] = result[c_msb];
    flags[FLG_Z] = (result == '0);
    case (op)
      OP_ADD: begin
        flags[FLG_C] = w_cout_add;
        flags[FLG_V] = w_cout_add ^ w_cin_add;
      end
      OP_SUB: begin
        flags[FLG_C] = w_cout_sub;
        flags[FLG_V] = w_cout_sub ^ w_cin_sub;
      end
      default: ;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
/*******************************************************************************
 * Module   : alu_pipe
 * Purpose  : Two-stage valid/ready ALU pipeline (operand stage, result stage).
 *            Define ALU_PIPE_FLAGS_EN to build the {N,V,C,Z} flag path.
 * Revision : 1.0 - initial release
 ******************************************************************************/
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       flags
);

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic [WIDTH-1:0] r_result;

  logic             w_s2_free;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_result;

  // in_ready ignores en so it keeps reporting the held state while stalled
  assign w_s2_free  = ~r_s2_valid | out_ready;
  assign in_ready   = ~clr & (~r_s1_valid | w_s2_free);
  assign w_in_xfer  = in_valid & in_ready & en;
  assign w_out_xfer = r_s2_valid & out_ready & en;
  assign w_s1_adv   = en & r_s1_valid & w_s2_free;

  assign out_valid  = r_s2_valid;
  assign alu_result = r_result;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_a        <= a;
      r_b        <= b;
      r_op       <= op;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_result;
    end else if (w_out_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] w_flags;
  logic [3:0] r_flags;

  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .result (w_result),
    .flags  (w_flags)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_flags <= 4'b0000;
    end else if (w_s1_adv) begin
      r_flags <= w_flags;
    end
  end

  assign flags = r_flags;
`else
  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .result (w_result)
  );

  assign flags = 4'b0000;
`endif

endmodule
`default_nettype wire
